// File: rtl/rf_write_arbiter_pkg.sv
// Register-file types and constants shared by the write-back arbiter, the decode
// stage (register locks) and the register file itself.
//   REG_ADDR_W : register address width
//   NUM_REGS   : architectural register count
//   RF_XLEN    : default register data width
//   rf_wr_req_t: one write-back request {valid, rd, data}
package rf_write_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned RF_XLEN    = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [RF_XLEN-1:0]    data;
  } rf_wr_req_t;

  // x0 is hardwired to zero: it is never written and never locked in decode.
  function automatic logic is_lockable(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter.
//   clk    : clock
//   rstn_i : asynchronous active-low reset (pointer returns to requester 0)
//   req_i  : request vector
//   gnt_o  : one-hot grant (combinational), all-zero when nothing requests
// The search starts at the pointer and wraps; after a grant the pointer moves to
// the requester just above the winner, so each active requester is served within N.
module rf_write_arbiter_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rstn_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [N-1:0]    req_hi;
  logic [N-1:0]    gnt_hi;
  logic [N-1:0]    gnt_lo;
  logic            found_hi;
  logic            found_lo;

  // Two-pass priority search: first among requesters at or above the pointer,
  // otherwise wrap to the lowest-indexed requester.
  always_comb begin
    req_hi   = '0;
    gnt_hi   = '0;
    gnt_lo   = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      req_hi[k] = req_i[k] && (PtrW'(k) >= ptr_q);
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_hi && req_hi[k]) begin
        found_hi  = 1'b1;
        gnt_hi[k] = 1'b1;
      end
      if (!found_lo && req_i[k]) begin
        found_lo  = 1'b1;
        gnt_lo[k] = 1'b1;
      end
    end
    gnt_o = found_hi ? gnt_hi : gnt_lo;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (gnt_o[k]) begin
        ptr_d = (k == N - 1) ? '0 : PtrW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: N_REQ write-back requesters share one write
// port, granted round-robin, one registered write per cycle.
//   clk          : clock
//   rstn_i       : asynchronous active-low reset
//   valid_i      : per-requester write pending (held with rd/data until acked)
//   rd_i, data_i : per-requester destination register and write data
//   ack_o        : one-hot grant, write consumed this cycle
//   we_o/wa_o/wd_o : registered register-file write (cycle after the ack)
//   rd_release_o : register to unlock in decode, aligned with the write; 0 = none
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                             clk,
  input  logic                             rstn_i,
  input  logic [N_REQ-1:0]                 valid_i,
  input  logic [N_REQ-1:0][REG_ADDR_W-1:0] rd_i,
  input  logic [N_REQ-1:0][XLEN-1:0]       data_i,
  output logic [N_REQ-1:0]                 ack_o,
  output logic                             we_o,
  output logic [REG_ADDR_W-1:0]            wa_o,
  output logic [XLEN-1:0]                  wd_o,
  output logic [REG_ADDR_W-1:0]            rd_release_o
);

  logic [N_REQ-1:0]      req_gated;
  logic                  gnt_any;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  logic [XLEN-1:0]       wd_q, wd_d;
  logic [REG_ADDR_W-1:0] rel_q, rel_d;

  // No grants while reset is held, so no requester believes its write was taken.
  assign req_gated = valid_i & {N_REQ{rstn_i}};

  rf_write_arbiter_rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req_i  (req_gated),
    .gnt_o  (ack_o)
  );

  // One-hot AND-OR mux of the winning request.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (ack_o[k]) begin
        sel_rd   = sel_rd | rd_i[k];
        sel_data = sel_data | data_i[k];
      end
    end
  end

  assign gnt_any = |ack_o;

  // Address/data only load on a grant; they are don't-care while we_o is low.
  // A write to x0 is consumed but turns into a no-op with no lock release.
  always_comb begin
    we_d  = 1'b0;
    rel_d = '0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    if (gnt_any) begin
      we_d  = is_lockable(sel_rd);
      rel_d = sel_rd;
      wa_d  = sel_rd;
      wd_d  = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      rel_q <= '0;
    end else begin
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      rel_q <= rel_d;
    end
  end

  assign we_o         = we_q;
  assign wa_o         = wa_q;
  assign wd_o         = wd_q;
  assign rd_release_o = rel_q;

  // Two concurrent writers to the same register means the decode lock was bypassed.
  logic dup_rd;
  always_comb begin
    dup_rd = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      for (int unsigned j = i + 1; j < N_REQ; j++) begin
        if (valid_i[i] && valid_i[j] && (rd_i[i] == rd_i[j]) && is_lockable(rd_i[i])) begin
          dup_rd = 1'b1;
        end
      end
    end
  end

  dup_rd_warn: assert property (@(posedge clk) disable iff (!rstn_i) !dup_rd)
    else $warning("rf_write_arbiter: two requesters target the same rd");

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int unsigned N2 = 2;
  localparam int unsigned N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_i;

  logic [N2-1:0]      valid2;
  logic [N2-1:0][4:0] rd2;
  logic [N2-1:0][31:0] data2;
  logic [N2-1:0]      ack2;
  logic               we2;
  logic [4:0]         wa2;
  logic [31:0]        wd2;
  logic [4:0]         rel2;

  logic [N3-1:0]      valid3;
  logic [N3-1:0][4:0] rd3;
  logic [N3-1:0][31:0] data3;
  logic [N3-1:0]      ack3;
  logic               we3;
  logic [4:0]         wa3;
  logic [31:0]        wd3;
  logic [4:0]         rel3;

  rf_write_arbiter #(.N_REQ(N2), .XLEN(32)) dut2 (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .valid_i      (valid2),
    .rd_i         (rd2),
    .data_i       (data2),
    .ack_o        (ack2),
    .we_o         (we2),
    .wa_o         (wa2),
    .wd_o         (wd2),
    .rd_release_o (rel2)
  );

  rf_write_arbiter #(.N_REQ(N3), .XLEN(32)) dut3 (
    .clk          (clk),
    .rstn_i       (rstn_i),
    .valid_i      (valid3),
    .rd_i         (rd3),
    .data_i       (data3),
    .ack_o        (ack3),
    .we_o         (we3),
    .wa_o         (wa3),
    .wd_o         (wd3),
    .rd_release_o (rel3)
  );

  // Register file fed by the 2-requester DUT.
  logic [31:0] rf [32] = '{default: '0};
  always @(posedge clk) begin
    if (we2) rf[wa2] <= wd2;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  ack;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rel;
  } vec_t;

  vec_t tbl [10];

  // Random-phase model state
  int          ptr;
  bit          pend [N2];
  logic [4:0]  prd  [N2];
  logic [31:0] pdat [N2];
  int          waitc [N2];
  logic        ewe;
  logic [4:0]  ewa;
  logic [31:0] ewd;
  logic [4:0]  erel;

  initial begin
    logic        pwe;
    logic [4:0]  pwa;
    logic [31:0] pwd;
    logic [4:0]  prel;
    logic [31:0] x7_before;
    int          gseq [6];
    int          g;
    int          pg;
    logic [31:0] pd;
    logic [31:0] exp_ack;
    bit          rst_now;

    // Reset: requests present but held off
    rstn_i = 1'b0;
    valid2 = 2'b11; rd2 = '0; data2 = '0;
    rd2[0] = 5'd1; rd2[1] = 5'd2;
    valid3 = '0; rd3 = '0; data3 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(ack2), 32'h0);
    check("reset_we", 32'(we2), 32'h0);
    check("reset_wa", 32'(wa2), 32'h0);
    check("reset_wd", wd2, 32'h0);
    check("reset_rel", 32'(rel2), 32'h0);
    @(posedge clk); #1;
    rstn_i = 1'b1;

    // Directed table: first grant, single write, idle, contention 0,1,0,1, x0, wrap
    tbl[0] = '{2'b11, 5'd1, 5'd5, 32'h11,       32'hDEADBEEF, 2'b01, 1'b1, 5'd1, 32'h11,       5'd1};
    tbl[1] = '{2'b10, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b10, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5};
    tbl[2] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0, 32'h0,        5'd0};
    tbl[3] = '{2'b11, 5'd3, 5'd4, 32'hA,        32'hB,        2'b01, 1'b1, 5'd3, 32'hA,        5'd3};
    tbl[4] = '{2'b11, 5'd6, 5'd4, 32'hC,        32'hB,        2'b10, 1'b1, 5'd4, 32'hB,        5'd4};
    tbl[5] = '{2'b11, 5'd6, 5'd8, 32'hC,        32'hD,        2'b01, 1'b1, 5'd6, 32'hC,        5'd6};
    tbl[6] = '{2'b11, 5'd9, 5'd8, 32'hE,        32'hD,        2'b10, 1'b1, 5'd8, 32'hD,        5'd8};
    tbl[7] = '{2'b01, 5'd0, 5'd0, 32'h1234,     32'h0,        2'b01, 1'b0, 5'd0, 32'h0,        5'd0};
    tbl[8] = '{2'b01, 5'd2, 5'd0, 32'hF,        32'h0,        2'b01, 1'b1, 5'd2, 32'hF,        5'd2};
    tbl[9] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 5'd0, 32'h0,        5'd0};

    pwe = 1'b0; pwa = '0; pwd = '0; prel = '0;
    for (int i = 0; i < 10; i++) begin
      valid2 = tbl[i].valid;
      rd2[0] = tbl[i].rd0;  rd2[1] = tbl[i].rd1;
      data2[0] = tbl[i].d0; data2[1] = tbl[i].d1;
      @(negedge clk);
      check($sformatf("tbl%0d_ack", i), 32'(ack2), 32'(tbl[i].ack));
      check($sformatf("tbl%0d_we", i), 32'(we2), 32'(pwe));
      check($sformatf("tbl%0d_rel", i), 32'(rel2), 32'(prel));
      if (pwe) begin
        check($sformatf("tbl%0d_wa", i), 32'(wa2), 32'(pwa));
        check($sformatf("tbl%0d_wd", i), wd2, pwd);
      end
      pwe = tbl[i].we; pwa = tbl[i].wa; pwd = tbl[i].wd; prel = tbl[i].rel;
      @(posedge clk); #1;
    end
    valid2 = '0;
    @(negedge clk);
    check("tbl_tail_we", 32'(we2), 32'(pwe));
    check("tbl_tail_rel", 32'(rel2), 32'(prel));
    check("rf_x5", rf[5], 32'hDEADBEEF);
    check("rf_x8", rf[8], 32'hD);
    check("rf_x0", rf[0], 32'h0);
    @(posedge clk); #1;

    // Reset with a write registered but not yet committed
    x7_before = rf[7];
    valid2 = 2'b01; rd2[0] = 5'd7; data2[0] = 32'h77777777;
    @(negedge clk);
    check("midrst_ack", 32'(ack2), 32'h1);
    @(posedge clk); #1;
    rstn_i = 1'b0; valid2 = '0;
    @(negedge clk);
    check("midrst_we", 32'(we2), 32'h0);
    check("midrst_rel", 32'(rel2), 32'h0);
    @(posedge clk); #1;
    rstn_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_after_we", 32'(we2), 32'h0);
      @(posedge clk); #1;
    end
    check("midrst_x7", rf[7], x7_before);

    // Three requesters, all continuously valid: 0,1,2,0,1,2
    gseq = '{0, 1, 2, 0, 1, 2};
    valid3 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      rd3[k] = 5'(10 + k);
      data3[k] = 32'h300 + 32'(k);
    end
    pg = -1; pd = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("wrap%0d_ack", c), 32'(ack3), 32'(1) << gseq[c]);
      if (pg >= 0) begin
        check($sformatf("wrap%0d_we", c), 32'(we3), 32'h1);
        check($sformatf("wrap%0d_wa", c), 32'(wa3), 32'(10 + pg));
        check($sformatf("wrap%0d_wd", c), wd3, pd);
      end
      pg = gseq[c];
      pd = data3[pg];
      @(posedge clk); #1;
      data3[pg] = $urandom;
    end
    valid3 = '0;
    @(negedge clk);
    check("wrap_tail_wa", 32'(wa3), 32'(10 + pg));
    check("wrap_tail_rel", 32'(rel3), 32'(10 + pg));
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_idle_we", 32'(we3), 32'h0);
    @(posedge clk); #1;

    // Randomized traffic with occasional resets against the reference model
    rstn_i = 1'b0;
    @(posedge clk); #1;
    rstn_i = 1'b1;
    ptr = 0; ewe = 1'b0; ewa = '0; ewd = '0; erel = '0;
    for (int k = 0; k < N2; k++) begin
      pend[k] = 1'b0; prd[k] = '0; pdat[k] = '0; waitc[k] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst_now = ($urandom_range(0, 63) == 0);
      rstn_i = !rst_now;
      if (rst_now) begin
        ptr = 0; ewe = 1'b0; ewa = '0; ewd = '0; erel = '0;
        for (int k = 0; k < N2; k++) waitc[k] = 0;
      end
      for (int k = 0; k < N2; k++) begin
        if (!pend[k] && $urandom_range(0, 3) != 0) begin
          pend[k] = 1'b1;
          prd[k]  = 5'(k * 8 + int'($urandom_range(0, 7)));
          pdat[k] = $urandom;
        end
        valid2[k] = pend[k];
        rd2[k]    = prd[k];
        data2[k]  = pdat[k];
      end
      @(negedge clk);
      g = -1;
      if (!rst_now) begin
        for (int j = 0; j < N2; j++) begin
          if (g < 0 && pend[(ptr + j) % N2]) g = (ptr + j) % N2;
        end
      end
      exp_ack = (g >= 0) ? (32'(1) << g) : 32'h0;
      check("rnd_ack", 32'(ack2), exp_ack);
      check("rnd_we", 32'(we2), 32'(ewe));
      check("rnd_rel", 32'(rel2), 32'(erel));
      if (ewe) begin
        check("rnd_wa", 32'(wa2), 32'(ewa));
        check("rnd_wd", wd2, ewd);
      end
      for (int k = 0; k < N2; k++) begin
        if (pend[k] && !rst_now) begin
          if (ack2[k]) waitc[k] = 0;
          else waitc[k]++;
          check("rnd_starve", 32'(waitc[k] >= int'(N2)), 32'h0);
        end
      end
      @(posedge clk);
      if (g >= 0) begin
        ewe  = (prd[g] != 5'd0);
        ewa  = prd[g];
        ewd  = pdat[g];
        erel = prd[g];
        ptr  = (g + 1) % N2;
        pend[g] = 1'b0;
      end else if (!rst_now) begin
        ewe  = 1'b0;
        erel = '0;
      end
      #1;
    end
    rstn_i = 1'b1;
    valid2 = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
